// File: rtl/bubbledrive8_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : bubbledrive8_pkg                                            |
// | Description: Shared types and defaults for the BubbleDrive8 flash        |
// |              arbiter: FSM state encoding, mux owner codes, and default   |
// |              guard/timeout lengths.                                      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package bubbledrive8_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMU_OWN = 2'd1,
    USB_OWN = 2'd2,
    GUARD   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_EMU  = 2'd1,
    OWN_USB  = 2'd2
  } owner_t;

  // Bus idle time after every release, in MCLK cycles.
  localparam int DEF_GUARD_CYC = 8;
  // 100 ms at 48 MHz.
  localparam int DEF_USB_TMO   = 4800000;

endpackage
`default_nettype wire

// File: rtl/bubbledrive8_romarb_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : bubbledrive8_romarb_mux                                     |
// | Description: Combinational SPI pin mux for the W25Q32. The select is the |
// |              registered owner code from the arbiter, so SPI data passes  |
// |              through with no added latency.                              |
// | Ports      : owner         - current bus owner (registered upstream)     |
// |              emu_*/usb_*   - nCS, CLK, MOSI, MOSI output-enable drives   |
// |              rom_ncs/clk   - flash chip select and clock                 |
// |              io0_out/oe    - flash IO0 data and its output enable        |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module bubbledrive8_romarb_mux
  import bubbledrive8_pkg::*;
(
  input  owner_t owner,
  input  logic   emu_ncs,
  input  logic   emu_clk,
  input  logic   emu_mosi,
  input  logic   emu_mosioe,
  input  logic   usb_ncs,
  input  logic   usb_clk,
  input  logic   usb_mosi,
  input  logic   usb_mosioe,
  output logic   rom_ncs,
  output logic   rom_clk,
  output logic   io0_out,
  output logic   io0_oe
);

  always_comb begin
    // Unowned bus: flash deselected, clock parked low, IO0 released.
    rom_ncs = 1'b1;
    rom_clk = 1'b0;
    io0_out = 1'b0;
    io0_oe  = 1'b0;
    case (owner)
      OWN_EMU: begin
        rom_ncs = emu_ncs;
        rom_clk = emu_clk;
        io0_out = emu_mosi;
        io0_oe  = emu_mosioe;
      end
      OWN_USB: begin
        rom_ncs = usb_ncs;
        rom_clk = usb_clk;
        io0_out = usb_mosi;
        io0_oe  = usb_mosioe;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bubbledrive8_romarb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : bubbledrive8_romarb                                         |
// | Description: Arbitrates the W25Q32 SPI flash between the emulator core   |
// |              and the USB/MPSSE side. The emulator has priority and is    |
// |              never preempted; USB is revoked on timeout or lock. Every   |
// |              release is followed by a GUARD_CYC-cycle idle bus.          |
// | Ports      : MCLK, nRESET         - clock, async active-low reset        |
// |              nEMUREQ/nEMUGNT      - emulator request/grant (active-low)  |
// |              EMU_*                - emulator SPI drive                   |
// |              nUSBREQ/nUSBGNT      - USB request/grant (active-low)       |
// |              USB_*                - USB SPI drive                        |
// |              nUSBABORT            - 1-cycle low on forced USB revoke     |
// |              nUSBLOCK             - low blocks any USB grant             |
// |              nROMCS/ROMCLK/ROMIO0 - flash pins; ROMIO1 is flash MISO     |
// |              ROMMISO              - ROMIO1 fanned out to both sides      |
// |              nBUSY                - low whenever not IDLE                |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module bubbledrive8_romarb
  import bubbledrive8_pkg::*;
#(
  parameter int GUARD_CYC = DEF_GUARD_CYC,
  parameter int USB_TMO   = DEF_USB_TMO
) (
  input  logic MCLK,
  input  logic nRESET,
  input  logic nEMUREQ,
  output logic nEMUGNT,
  input  logic EMU_nCS,
  input  logic EMU_CLK,
  input  logic EMU_MOSI,
  input  logic EMU_MOSIOE,
  input  logic nUSBREQ,
  output logic nUSBGNT,
  input  logic USB_nCS,
  input  logic USB_CLK,
  input  logic USB_MOSI,
  input  logic USB_MOSIOE,
  output logic nUSBABORT,
  input  logic nUSBLOCK,
  output logic nROMCS,
  output logic ROMCLK,
  inout  wire  ROMIO0,
  input  logic ROMIO1,
  output logic ROMMISO,
  output logic nBUSY
);

  localparam int GW = $clog2(GUARD_CYC + 1);
  localparam int TW = $clog2(USB_TMO + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(USB_TMO - 1);

  state_t          state;
  owner_t          owner;
  logic [GW-1:0]   guard_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            emu_gnt_n;
  logic            usb_gnt_n;
  logic            abort_n;
  logic            busy_n;
  logic            io0_out;
  logic            io0_oe;

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      guard_cnt <= '0;
      tmo_cnt   <= '0;
      emu_gnt_n <= 1'b1;
      usb_gnt_n <= 1'b1;
      abort_n   <= 1'b1;
      busy_n    <= 1'b1;
    end else begin
      abort_n <= 1'b1;
      case (state)
        IDLE: begin
          // Emulator checked first so it wins a simultaneous request.
          if (!nEMUREQ) begin
            state     <= EMU_OWN;
            owner     <= OWN_EMU;
            emu_gnt_n <= 1'b0;
            busy_n    <= 1'b0;
          end else if (!nUSBREQ && nUSBLOCK) begin
            state     <= USB_OWN;
            owner     <= OWN_USB;
            usb_gnt_n <= 1'b0;
            busy_n    <= 1'b0;
            tmo_cnt   <= '0;
          end
        end

        EMU_OWN: begin
          if (nEMUREQ) begin
            state     <= GUARD;
            owner     <= OWN_NONE;
            emu_gnt_n <= 1'b1;
            guard_cnt <= '0;
          end
        end

        USB_OWN: begin
          if (!nUSBLOCK || (!nEMUREQ && nUSBREQ == 1'b0 && tmo_cnt == TMO_LAST)) begin
            // Forced revoke: lock asserted or emulator starved too long.
            state     <= GUARD;
            owner     <= OWN_NONE;
            usb_gnt_n <= 1'b1;
            abort_n   <= 1'b0;
            guard_cnt <= '0;
            tmo_cnt   <= '0;
          end else if (nUSBREQ) begin
            state     <= GUARD;
            owner     <= OWN_NONE;
            usb_gnt_n <= 1'b1;
            guard_cnt <= '0;
            tmo_cnt   <= '0;
          end else if (!nEMUREQ) begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end else begin
            // Timeout measures only continuous emulator waiting.
            tmo_cnt <= '0;
          end
        end

        GUARD: begin
          if (guard_cnt == GUARD_LAST) begin
            state     <= IDLE;
            busy_n    <= 1'b1;
            guard_cnt <= '0;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end

        default: begin
          state     <= IDLE;
          owner     <= OWN_NONE;
          emu_gnt_n <= 1'b1;
          usb_gnt_n <= 1'b1;
          busy_n    <= 1'b1;
        end
      endcase
    end
  end

  bubbledrive8_romarb_mux u_mux (
    .owner      (owner),
    .emu_ncs    (EMU_nCS),
    .emu_clk    (EMU_CLK),
    .emu_mosi   (EMU_MOSI),
    .emu_mosioe (EMU_MOSIOE),
    .usb_ncs    (USB_nCS),
    .usb_clk    (USB_CLK),
    .usb_mosi   (USB_MOSI),
    .usb_mosioe (USB_MOSIOE),
    .rom_ncs    (nROMCS),
    .rom_clk    (ROMCLK),
    .io0_out    (io0_out),
    .io0_oe     (io0_oe)
  );

  assign ROMIO0    = io0_oe ? io0_out : 1'bz;
  assign ROMMISO   = ROMIO1;
  assign nEMUGNT   = emu_gnt_n;
  assign nUSBGNT   = usb_gnt_n;
  assign nUSBABORT = abort_n;
  assign nBUSY     = busy_n;

endmodule
`default_nettype wire

// File: tb/tb_bubbledrive8_romarb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_bubbledrive8_romarb                                      |
// | Description: Self-checking bench for bubbledrive8_romarb with short      |
// |              guard/timeout parameters and randomized traffic.            |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_bubbledrive8_romarb;

  localparam int GUARD_CYC = 8;
  localparam int USB_TMO   = 16;

  logic MCLK = 1'b0;
  logic nRESET, nEMUREQ, EMU_nCS, EMU_CLK, EMU_MOSI, EMU_MOSIOE;
  logic nUSBREQ, USB_nCS, USB_CLK, USB_MOSI, USB_MOSIOE, nUSBLOCK, ROMIO1;
  logic nEMUGNT, nUSBGNT, nUSBABORT, nROMCS, ROMCLK, ROMMISO, nBUSY;
  wire  ROMIO0;

  int checks = 0;
  int errors = 0;

  bubbledrive8_romarb #(.GUARD_CYC(GUARD_CYC), .USB_TMO(USB_TMO)) dut (
    .MCLK(MCLK), .nRESET(nRESET),
    .nEMUREQ(nEMUREQ), .nEMUGNT(nEMUGNT),
    .EMU_nCS(EMU_nCS), .EMU_CLK(EMU_CLK), .EMU_MOSI(EMU_MOSI), .EMU_MOSIOE(EMU_MOSIOE),
    .nUSBREQ(nUSBREQ), .nUSBGNT(nUSBGNT),
    .USB_nCS(USB_nCS), .USB_CLK(USB_CLK), .USB_MOSI(USB_MOSI), .USB_MOSIOE(USB_MOSIOE),
    .nUSBABORT(nUSBABORT), .nUSBLOCK(nUSBLOCK),
    .nROMCS(nROMCS), .ROMCLK(ROMCLK), .ROMIO0(ROMIO0), .ROMIO1(ROMIO1),
    .ROMMISO(ROMMISO), .nBUSY(nBUSY)
  );

  always #5 MCLK = ~MCLK;

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  // Waits for the bus to return to IDLE; reports cycles taken and how many
  // of them showed the flash selected (both sides drive nCS low meanwhile).
  task automatic wait_idle(output int n, output int cs_low);
    n = 0;
    cs_low = 0;
    EMU_nCS = 1'b0;
    USB_nCS = 1'b0;
    while (nBUSY !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (nBUSY !== 1'b1 && nROMCS !== 1'b1) cs_low++;
    end
  endtask

  task automatic rand_spi();
    {EMU_nCS, EMU_CLK, EMU_MOSI, EMU_MOSIOE} = 4'($urandom);
    {USB_nCS, USB_CLK, USB_MOSI, USB_MOSIOE} = 4'($urandom);
    ROMIO1 = 1'($urandom);
  endtask

  task automatic test_reset();
    nRESET = 1'b1;
    #2 nRESET = 1'b0;
    tick(); tick();
    checks++; if (nEMUGNT !== 1'b1) begin errors++; $display("FAIL reset_nEMUGNT got %b exp 1", nEMUGNT); end
    checks++; if (nUSBGNT !== 1'b1) begin errors++; $display("FAIL reset_nUSBGNT got %b exp 1", nUSBGNT); end
    checks++; if (nUSBABORT !== 1'b1) begin errors++; $display("FAIL reset_nUSBABORT got %b exp 1", nUSBABORT); end
    checks++; if (nBUSY !== 1'b1) begin errors++; $display("FAIL reset_nBUSY got %b exp 1", nBUSY); end
    checks++; if ({nROMCS, ROMCLK} !== 2'b10) begin errors++; $display("FAIL reset_pins got %b%b exp 10", nROMCS, ROMCLK); end
    @(negedge MCLK);
    nRESET = 1'b1;
    tick();
  endtask

  // Both request on the same edge: emulator wins and owns the pins.
  task automatic test_simultaneous();
    int n, cs_low;
    nEMUREQ = 1'b0; nUSBREQ = 1'b0;
    tick();
    checks++; if ({nEMUGNT, nUSBGNT} !== 2'b01) begin errors++; $display("FAIL simul_grant got %b%b exp 01", nEMUGNT, nUSBGNT); end
    checks++; if (nBUSY !== 1'b0) begin errors++; $display("FAIL simul_busy got %b exp 0", nBUSY); end
    for (int i = 0; i < 6; i++) begin
      rand_spi();
      EMU_MOSIOE = 1'b1;
      #1;
      checks++;
      if ({nROMCS, ROMCLK, ROMIO0, ROMMISO} !== {EMU_nCS, EMU_CLK, EMU_MOSI, ROMIO1}) begin
        errors++;
        $display("FAIL simul_mux got %b%b%b%b exp %b%b%b%b", nROMCS, ROMCLK, ROMIO0, ROMMISO,
                 EMU_nCS, EMU_CLK, EMU_MOSI, ROMIO1);
      end
      tick();
      checks++; if (nUSBGNT !== 1'b1) begin errors++; $display("FAIL simul_usb_held got %b exp 1", nUSBGNT); end
    end
    nEMUREQ = 1'b1; nUSBREQ = 1'b1;
    tick();
    checks++; if (nEMUGNT !== 1'b1) begin errors++; $display("FAIL simul_release got %b exp 1", nEMUGNT); end
    wait_idle(n, cs_low);
    checks++; if (n !== GUARD_CYC) begin errors++; $display("FAIL simul_guard_len got %0d exp %0d", n, GUARD_CYC); end
  endtask

  // USB releases; an emulator request made during GUARD waits it out.
  task automatic test_usb_guard();
    int n, cs_low, k;
    nUSBREQ = 1'b0;
    tick();
    checks++; if ({nEMUGNT, nUSBGNT} !== 2'b10) begin errors++; $display("FAIL usbg_grant got %b%b exp 10", nEMUGNT, nUSBGNT); end
    for (int i = 0; i < 4; i++) begin
      rand_spi();
      USB_MOSIOE = 1'b1;
      #1;
      checks++;
      if ({nROMCS, ROMCLK, ROMIO0} !== {USB_nCS, USB_CLK, USB_MOSI}) begin
        errors++;
        $display("FAIL usbg_mux got %b%b%b exp %b%b%b", nROMCS, ROMCLK, ROMIO0, USB_nCS, USB_CLK, USB_MOSI);
      end
      tick();
    end
    nUSBREQ = 1'b1;
    tick();
    checks++; if (nUSBGNT !== 1'b1) begin errors++; $display("FAIL usbg_release got %b exp 1", nUSBGNT); end
    EMU_nCS = 1'b0; USB_nCS = 1'b0;
    k = int'($urandom_range(1, GUARD_CYC - 2));
    n = 0; cs_low = 0;
    // n counts edges after the release edge; guard ends after GUARD_CYC of
    // them, and the IDLE edge that follows issues the grant.
    while (nEMUGNT !== 1'b0 && n < 40) begin
      if (n == k) nEMUREQ = 1'b0;
      tick();
      n++;
      if (nEMUGNT !== 1'b0 && nROMCS !== 1'b1) cs_low++;
    end
    checks++; if (n !== GUARD_CYC + 1) begin errors++; $display("FAIL usbg_emu_wait got %0d exp %0d", n, GUARD_CYC + 1); end
    checks++; if (cs_low !== 0) begin errors++; $display("FAIL usbg_cs_in_guard got %0d exp 0", cs_low); end
    checks++; if (nROMCS !== EMU_nCS) begin errors++; $display("FAIL usbg_emu_cs got %b exp %b", nROMCS, EMU_nCS); end
    nEMUREQ = 1'b1;
    tick();
    wait_idle(n, cs_low);
    checks++; if (cs_low !== 0) begin errors++; $display("FAIL usbg_cs_guard2 got %0d exp 0", cs_low); end
  endtask

  // Timeout: count only continuous emulator waiting samples.
  task automatic test_timeout();
    int run, n, cs_low, pre, aborted_at;
    bit expect_abort;
    nUSBREQ = 1'b0;
    tick();
    checks++; if (nUSBGNT !== 1'b0) begin errors++; $display("FAIL tmo_grant got %b exp 0", nUSBGNT); end
    run = 0;
    aborted_at = -1;
    pre = int'($urandom_range(0, 10));
    for (int c = 0; c < pre + USB_TMO + 2 && aborted_at < 0; c++) begin
      // Random pre-phase (runs stay shorter than USB_TMO), then a clear,
      // then a continuous wait.
      if (c < pre)       nEMUREQ = 1'($urandom);
      else if (c == pre) nEMUREQ = 1'b1;
      else               nEMUREQ = 1'b0;
      run = (nEMUREQ == 1'b0) ? run + 1 : 0;
      expect_abort = (run == USB_TMO);
      tick();
      checks++;
      if (nUSBABORT !== !expect_abort) begin
        errors++;
        $display("FAIL tmo_abort cycle %0d got %b exp %b", c, nUSBABORT, !expect_abort);
      end
      if (expect_abort) aborted_at = c;
    end
    checks++; if (aborted_at - pre !== USB_TMO) begin errors++; $display("FAIL tmo_when got %0d exp %0d", aborted_at - pre, USB_TMO); end
    checks++; if (nUSBGNT !== 1'b1) begin errors++; $display("FAIL tmo_revoke got %b exp 1", nUSBGNT); end
    nUSBREQ = 1'b1;
    n = 0;
    while (nEMUGNT !== 1'b0 && n < 40) begin
      tick();
      n++;
      if (nUSBABORT !== 1'b1) begin
        checks++; errors++;
        $display("FAIL tmo_pulse_width got %b exp 1", nUSBABORT);
      end
    end
    checks++; if (n !== GUARD_CYC + 1) begin errors++; $display("FAIL tmo_emu_after got %0d exp %0d", n, GUARD_CYC + 1); end
    nEMUREQ = 1'b1;
    tick();
    wait_idle(n, cs_low);
  endtask

  // Lock falling revokes USB at once; locked USB requests are ignored.
  task automatic test_lock();
    int aborts;
    nUSBREQ = 1'b0;
    tick();
    checks++; if (nUSBGNT !== 1'b0) begin errors++; $display("FAIL lock_grant got %b exp 0", nUSBGNT); end
    repeat (int'($urandom_range(1, 5))) tick();
    nUSBLOCK = 1'b0;
    tick();
    checks++; if ({nUSBGNT, nUSBABORT} !== 2'b10) begin errors++; $display("FAIL lock_revoke got %b%b exp 10", nUSBGNT, nUSBABORT); end
    aborts = 0;
    for (int c = 0; c < GUARD_CYC + 10; c++) begin
      tick();
      if (nUSBABORT !== 1'b1) aborts++;
      checks++;
      if (nUSBGNT !== 1'b1) begin errors++; $display("FAIL lock_ignored cycle %0d got %b exp 1", c, nUSBGNT); end
    end
    checks++; if (aborts !== 0) begin errors++; $display("FAIL lock_extra_abort got %0d exp 0", aborts); end
    checks++; if (nBUSY !== 1'b1) begin errors++; $display("FAIL lock_idle got %b exp 1", nBUSY); end
    nUSBLOCK = 1'b1;
    tick();
    checks++; if (nUSBGNT !== 1'b0) begin errors++; $display("FAIL lock_regrant got %b exp 0", nUSBGNT); end
    nUSBREQ = 1'b1;
    tick();
    begin
      int n, cs_low;
      wait_idle(n, cs_low);
    end
  endtask

  // Reset mid-transfer: outputs drop at once, no guard, then re-grant.
  task automatic test_reset_mid();
    int n, cs_low;
    nEMUREQ = 1'b0;
    tick();
    EMU_nCS = 1'b0; EMU_CLK = 1'b1;
    #1;
    checks++; if ({nEMUGNT, nROMCS} !== 2'b00) begin errors++; $display("FAIL rmid_owned got %b%b exp 00", nEMUGNT, nROMCS); end
    #1 nRESET = 1'b0;
    #1;
    checks++;
    if ({nEMUGNT, nUSBGNT, nUSBABORT, nBUSY, nROMCS, ROMCLK} !== 6'b111110) begin
      errors++;
      $display("FAIL rmid_async got %b%b%b%b%b%b exp 111110", nEMUGNT, nUSBGNT, nUSBABORT, nBUSY, nROMCS, ROMCLK);
    end
    @(negedge MCLK);
    nRESET = 1'b1;
    tick();
    checks++; if ({nEMUGNT, nBUSY} !== 2'b00) begin errors++; $display("FAIL rmid_regrant got %b%b exp 00", nEMUGNT, nBUSY); end
    nEMUREQ = 1'b1;
    tick();
    wait_idle(n, cs_low);
    checks++; if (n !== GUARD_CYC) begin errors++; $display("FAIL rmid_guard got %0d exp %0d", n, GUARD_CYC); end
  endtask

  // Random owners, hold lengths and SPI data; model: the chosen side's pins
  // appear at the flash while granted, the bus is idle for GUARD_CYC after.
  task automatic test_back_to_back();
    int n, cs_low, hold;
    bit use_emu;
    for (int t = 0; t < 12; t++) begin
      use_emu = 1'($urandom);
      hold = int'($urandom_range(1, 6));
      if (use_emu) nEMUREQ = 1'b0; else nUSBREQ = 1'b0;
      tick();
      checks++;
      if ({nEMUGNT, nUSBGNT} !== (use_emu ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL b2b_grant t%0d got %b%b exp %b", t, nEMUGNT, nUSBGNT, use_emu ? 2'b01 : 2'b10);
      end
      for (int h = 0; h < hold; h++) begin
        rand_spi();
        #1;
        checks++;
        if ({nROMCS, ROMCLK, ROMMISO} !== (use_emu ? {EMU_nCS, EMU_CLK, ROMIO1} : {USB_nCS, USB_CLK, ROMIO1})) begin
          errors++;
          $display("FAIL b2b_mux t%0d got %b%b%b", t, nROMCS, ROMCLK, ROMMISO);
        end
        if (use_emu ? EMU_MOSIOE : USB_MOSIOE) begin
          checks++;
          if (ROMIO0 !== (use_emu ? EMU_MOSI : USB_MOSI)) begin
            errors++;
            $display("FAIL b2b_io0 t%0d got %b exp %b", t, ROMIO0, use_emu ? EMU_MOSI : USB_MOSI);
          end
        end
        tick();
      end
      nEMUREQ = 1'b1; nUSBREQ = 1'b1;
      tick();
      wait_idle(n, cs_low);
      checks++;
      if (n !== GUARD_CYC || cs_low !== 0) begin
        errors++;
        $display("FAIL b2b_guard t%0d got %0d/%0d exp %0d/0", t, n, cs_low, GUARD_CYC);
      end
    end
  endtask

  initial begin
    nRESET = 1'b1;
    nEMUREQ = 1'b1; nUSBREQ = 1'b1; nUSBLOCK = 1'b1;
    {EMU_nCS, EMU_CLK, EMU_MOSI, EMU_MOSIOE} = 4'b1000;
    {USB_nCS, USB_CLK, USB_MOSI, USB_MOSIOE} = 4'b1000;
    ROMIO1 = 1'b0;
    test_reset();
    test_simultaneous();
    test_usb_guard();
    test_timeout();
    test_lock();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bubbledrive8_romarb.md
BUBBLEDRIVE8_ROMARB -- requirements
Module: bubbledrive8_romarb

Interface
REQ-001 SHALL have parameter GUARD_CYC, default 8: MCLK cycles the bus is held idle, with nROMCS high, after each release.
REQ-002 SHALL have parameter USB_TMO, default 4800000: maximum MCLK cycles USB may keep the grant while the emulator is requesting (100 ms at 48 MHz).
REQ-003 SHALL have port MCLK, input, 1 bit: the 48 MHz clock, and the only clock.
REQ-004 SHALL have port nRESET, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports nEMUREQ, input, 1, and nEMUGNT, output, 1: emulator-core flash request/grant, active-low.
REQ-006 SHALL have inputs EMU_nCS, EMU_CLK, EMU_MOSI and EMU_MOSIOE, 1 bit each: the emulator's SPI drive.
REQ-007 SHALL have ports nUSBREQ, input, 1, and nUSBGNT, output, 1: USB/MPSSE flash request/grant, active-low.
REQ-008 SHALL have inputs USB_nCS, USB_CLK, USB_MOSI and USB_MOSIOE, 1 bit each: the USB side's SPI drive.
REQ-009 SHALL have output nUSBABORT, 1 bit: one-cycle low pulse when a USB grant is revoked by timeout.
REQ-010 SHALL have input nUSBLOCK, 1 bit: when low, USB is never granted (emulator mode is active).
REQ-011 SHALL have outputs nROMCS and ROMCLK, inout ROMIO0, and input ROMIO1 (MISO), 1 bit each: the W25Q32 pins.
REQ-012 SHALL have output ROMMISO, 1 bit: ROMIO1 passed through to both requesters.
REQ-013 SHALL have output nBUSY, 1 bit: low whenever the state is not IDLE.

Function
REQ-014 SHALL have the states IDLE, EMU_OWN, USB_OWN and GUARD.
REQ-015 In IDLE, nEMUREQ sampled low SHALL move to EMU_OWN; else nUSBREQ low with nUSBLOCK high SHALL move to USB_OWN; the emulator wins a simultaneous request.
REQ-016 nEMUGNT/nUSBGNT SHALL be registered and go low on the first clock edge after the request is sampled, so grant latency is 1 cycle.
REQ-017 In an OWN state, the owner's request high SHALL deassert the grant on the next edge and enter GUARD.
REQ-018 GUARD SHALL last exactly GUARD_CYC cycles, then return to IDLE; requests that arrive during GUARD SHALL wait.
REQ-019 In USB_OWN, the timeout counter SHALL increment only while nEMUREQ is low and SHALL clear whenever nEMUREQ is high.
REQ-020 When the timeout counter reaches USB_TMO-1, the block SHALL revoke nUSBGNT, pulse nUSBABORT low for 1 cycle and enter GUARD.
REQ-021 When nUSBLOCK falls during USB_OWN, the block SHALL revoke the grant immediately, with the same abort pulse and GUARD entry as REQ-020.
REQ-022 There SHALL be no preemption of EMU_OWN.
REQ-023 Pin mux in EMU_OWN: nROMCS=EMU_nCS, ROMCLK=EMU_CLK, ROMIO0 driven by EMU_MOSI when EMU_MOSIOE=1, else hi-Z.
REQ-024 Pin mux in USB_OWN: as REQ-023, using the USB inputs.
REQ-025 In IDLE and GUARD: nROMCS=1, ROMCLK=0, ROMIO0 hi-Z.
REQ-026 The mux select SHALL be a registered owner code, with combinational data paths only, so the mux adds no cycle of latency to SPI data.
REQ-027 The GUARD counter width SHALL be $clog2(GUARD_CYC+1) and the timeout counter width $clog2(USB_TMO+1); neither counter shall wrap.

Reset
REQ-028 While nRESET is low: state IDLE; nEMUGNT=1, nUSBGNT=1, nUSBABORT=1, nBUSY=1; nROMCS=1, ROMCLK=0, ROMIO0 hi-Z; counters 0.
REQ-029 Reset mid-transfer SHALL drop the grant and nROMCS asynchronously, with no GUARD phase.

Structure
REQ-030 The state encoding, owner codes and default GUARD_CYC/USB_TMO values SHALL live in the shared package bubbledrive8_pkg.
REQ-031 The pin mux SHALL be a sub-module, bubbledrive8_romarb_mux, with the FSM and counters in the parent.

Verification
REQ-032 nEMUREQ and nUSBREQ low on the same edge -> nEMUGNT low 1 cycle later; nUSBGNT stays 1; nROMCS follows EMU_nCS.
REQ-033 USB owns the bus and releases -> nROMCS=1 for exactly 8 cycles; an emulator request arriving in GUARD is granted on cycle 9.
REQ-034 USB_TMO=16; USB holds the bus while nEMUREQ is low -> nUSBABORT pulses on cycle 16, then after GUARD nEMUGNT goes low.
REQ-035 nUSBLOCK falls during USB_OWN -> nUSBGNT=1 on the next edge, one nUSBABORT pulse; further USB requests are ignored while locked.
REQ-036 nRESET asserted mid-transfer in EMU_OWN -> all outputs take their reset values immediately; after release the block returns to IDLE and re-grants.
